mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbiter and sequencer for the single shared memory port of the RV32 core.
- Shares the port between instruction fetch (IF, read-only) and the load/store path (LSU, driven by decoded load/store instructions).
- Allows one outstanding transaction at a time.
- Fixed LSU priority, with a starvation guard that forces an IF grant after a bounded LSU streak, and IF-response dropping on pipeline flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
MAX_STREAK, 4, consecutive LSU wins allowed while IF waits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  IF address
if_flush  in  1  discard any in-flight IF response
if_gnt  out  1  IF request accepted by memory
if_rvalid  out  1  IF read data valid
if_rdata  out  DATA_W  IF read data
lsu_req  in  1  LSU request; held with fields until lsu_gnt
lsu_we  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  store data
lsu_be  in  DATA_W/8  byte enables
lsu_gnt  out  1  LSU request accepted by memory
lsu_rvalid  out  1  load data valid / store acknowledged
lsu_rdata  out  DATA_W  load data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response (reads and writes)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. The clock port is named clk and the reset port is named rst_n.
- Reset values:
  - FSM in IDLE; owner = IF; streak = 0; drop = 0.
  - mem_req, mem_we = 0; mem_addr, mem_wdata, mem_be = 0.
  - All gnt and rvalid outputs = 0.
  - Reset asserted mid-transaction aborts immediately: mem_req drops asynchronously and no response is forwarded.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is present, arbitrate and register owner and the winner's fields into the mem_* registers, then go to REQ.
  - Fields for an IF winner: we = 0, be = all ones, wdata = 0.
  - mem_req is registered and rises the cycle after the request is seen (latency 1).
- Arbitration:
  - LSU wins unless streak == MAX_STREAK and if_req = 1; in that case IF wins.
  - streak increments on an LSU win while if_req = 1, saturating at MAX_STREAK.
  - streak clears on an IF win, and on an LSU win with if_req = 0.
- REQ:
  - mem_req = 1 and all mem_* fields are held stable until mem_gnt.
  - On the mem_gnt cycle, the owner's gnt pulses combinationally (if_gnt or lsu_gnt) for exactly that cycle.
  - Then mem_req deasserts on the next edge and the FSM goes to RESP.
- RESP:
  - mem_rvalid passes combinationally to the owner's rvalid, and mem_rdata to both rdata outputs; then go to IDLE.
  - A store completes only on mem_rvalid.
  - mem_rvalid outside RESP is ignored.
  - mem_rvalid in the same cycle as mem_gnt is not supported; the memory responds at least 1 cycle after gnt.
- Throughput:
  - Minimum transaction = 3 cycles (REQ, RESP, IDLE).
  - One idle bubble between back-to-back transactions.
- Requester rules: each requester holds req and its fields until gnt. Deasserting req before gnt is a requester error; the latched copy is still issued.
- Flush:
  - if_flush with owner = IF in REQ or RESP sets drop. The memory transaction still completes.
  - While drop = 1, if_rvalid is suppressed, including when if_flush coincides with mem_rvalid.
  - drop clears on entry to IDLE.
  - if_flush in IDLE has no effect.
  - if_flush never affects LSU transactions.
- Simultaneous if_req and lsu_req in IDLE: resolved per the arbitration rule; the loser waits with req held.

Test Plan:
- Single LSU load to 0x100; mem_gnt on the 2nd REQ cycle; mem_rvalid 2 cycles later with rdata 0xDEADBEEF -> mem_req high 2 cycles, lsu_gnt 1 pulse, lsu_rvalid 1 pulse with 0xDEADBEEF; if_rvalid stays 0.
- LSU store to 0x200, be = 0x3, wdata = 0x1234 -> mem_we = 1, mem_be = 0x3, mem_wdata = 0x1234 stable until gnt; lsu_rvalid pulses on the write ack.
- if_req and lsu_req held continuously, MAX_STREAK = 4, mem_gnt/rvalid immediate -> grant order L, L, L, L, I, L, L, L, L, I; streak returns to 0 after each IF grant.
- IF fetch at 0x40 granted, then if_flush during RESP before mem_rvalid -> mem transaction completes; if_rvalid stays 0; the next IF fetch returns data normally.
- if_flush in the same cycle as mem_rvalid for an IF transaction -> if_rvalid = 0. If that IF fetch had started while an LSU transaction was active, lsu_rvalid for the LSU transaction is unaffected.
- rst_n pulsed low while in REQ with mem_req = 1 -> mem_req = 0 immediately; FSM in IDLE; a late mem_rvalid after reset produces no rvalid output; streak = 0.

Source files
------------

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares the single memory port of the RV32 core between
// instruction fetch (read-only) and the load/store unit. Only one
// transaction is outstanding at a time. The LSU normally wins arbitration.
// A streak counter stops the LSU from starving IF: after MAX_STREAK
// consecutive LSU wins while IF is waiting, IF gets the next grant.
// An IF response can be dropped when the pipeline flushes.

module mem_port_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  // instruction fetch side (read-only)
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  // load/store side
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,

  // shared memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  // The counter must be able to hold MAX_STREAK itself.
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            owner_lsu;   // 0 = IF owns the transaction, 1 = LSU
  logic [SW-1:0]   streak;      // consecutive LSU wins while IF was waiting
  logic            drop;        // discard the in-flight IF response

  logic            any_req;
  logic            if_wins;
  logic [SW-1:0]   streak_next;
  logic            if_owner_flush;

  // Arbitration decision for the IDLE cycle: LSU priority unless IF has
  // already waited through a full streak of LSU grants.
  always_comb begin
    any_req = if_req | lsu_req;
    if_wins = if_req & (~lsu_req | (streak == STREAK_MAX));
  end

  // Streak bookkeeping: count LSU wins that made IF wait, saturating;
  // clear on an IF win or on an LSU win nobody else wanted the port for.
  always_comb begin
    streak_next = '0;
    if (!if_wins && if_req) begin
      if (streak == STREAK_MAX) begin
        streak_next = streak;
      end else begin
        streak_next = streak + SW'(1);
      end
    end
  end

  // A flush only matters while IF owns a transaction that is in flight.
  always_comb begin
    if_owner_flush = if_flush & ~owner_lsu & ((state == REQ) | (state == RESP));
  end

  // Grants pulse combinationally on the memory accept cycle for the owner;
  // responses pass straight through to the owner during RESP.
  always_comb begin
    if_gnt     = (state == REQ)  & mem_gnt    & ~owner_lsu;
    lsu_gnt    = (state == REQ)  & mem_gnt    &  owner_lsu;
    if_rvalid  = (state == RESP) & mem_rvalid & ~owner_lsu & ~drop & ~if_flush;
    lsu_rvalid = (state == RESP) & mem_rvalid &  owner_lsu;
    if_rdata   = mem_rdata;
    lsu_rdata  = mem_rdata;
  end

  // Transaction sequencer: latch the winner into the port registers, hold
  // them until accepted, then wait for the single response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      streak    <= '0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (any_req) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            owner_lsu <= ~if_wins;
            streak    <= if_wins ? '0 : streak_next;
            if (if_wins) begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= {BE_W{1'b1}};
            end else begin
              mem_we    <= lsu_we;
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
              mem_be    <= lsu_be;
            end
          end
        end

        REQ: begin
          if (if_owner_flush) begin
            drop <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end

        RESP: begin
          if (mem_rvalid) begin
            // Returning to IDLE always forgets any pending drop.
            state <= IDLE;
            drop  <= 1'b0;
          end else if (if_owner_flush) begin
            drop <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          drop    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb. Inputs change just after the falling
// edge; outputs are checked 1 time unit later, so registered outputs show
// the state from the previous rising edge and combinational outputs show
// the response to the freshly driven inputs.

module tb_mem_port_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_flush;
  logic                if_gnt;
  logic                if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                lsu_req;
  logic                lsu_we;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_be;
  logic                lsu_gnt;
  logic                lsu_rvalid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_be     (lsu_be),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next falling edge, where new inputs get driven.
  task automatic nxt();
    @(negedge clk);
  endtask

  // Expected grant order with both requesters held: 1 = IF, 0 = LSU.
  logic [9:0] exp_if_order;
  logic [2:0] exp_streak [10];

  initial begin
    exp_if_order = 10'b1000010000;  // bit k = transaction k (LSB first)
    exp_streak   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // ---------------- reset state ----------------
    nxt(); #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_gnts", 64'({if_gnt, lsu_gnt}), 64'd0);
    chk("rst_streak", 64'(dut.streak), 64'd0);
    nxt(); rst_n = 1'b1;

    // ---------------- single LSU load ----------------
    nxt(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100; lsu_be = 4'hF; #1;
    chk("ld_req_latency", 64'(mem_req), 64'd0);
    $display("load 0x100 requested");
    nxt(); #1;
    chk("ld_req_c1", 64'(mem_req), 64'd1);
    chk("ld_addr", 64'(mem_addr), 64'h100);
    chk("ld_we", 64'(mem_we), 64'd0);
    chk("ld_no_gnt", 64'(lsu_gnt), 64'd0);
    nxt(); mem_gnt = 1'b1; #1;
    chk("ld_req_c2", 64'(mem_req), 64'd1);
    chk("ld_lsu_gnt", 64'(lsu_gnt), 64'd1);
    chk("ld_if_gnt", 64'(if_gnt), 64'd0);
    nxt(); mem_gnt = 1'b0; lsu_req = 1'b0; #1;
    chk("ld_req_drop", 64'(mem_req), 64'd0);
    chk("ld_gnt_pulse", 64'(lsu_gnt), 64'd0);
    chk("ld_rvalid_early", 64'(lsu_rvalid), 64'd0);
    nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_rvalid", 64'(lsu_rvalid), 64'd1);
    chk("ld_rdata", 64'(lsu_rdata), 64'hDEADBEEF);
    chk("ld_if_rvalid", 64'(if_rvalid), 64'd0);
    $display("load 0x100 returned %h", lsu_rdata);
    nxt(); mem_rvalid = 1'b0; #1;
    chk("ld_rvalid_pulse", 64'(lsu_rvalid), 64'd0);
    chk("ld_idle_req", 64'(mem_req), 64'd0);

    // ---------------- LSU store ----------------
    nxt(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200; lsu_be = 4'h3; lsu_wdata = 32'h1234;
    nxt(); lsu_wdata = 32'hFFFF; lsu_be = 4'hC; #1;  // requester changing fields is ignored
    chk("st_we", 64'(mem_we), 64'd1);
    chk("st_be", 64'(mem_be), 64'h3);
    chk("st_wdata", 64'(mem_wdata), 64'h1234);
    chk("st_addr", 64'(mem_addr), 64'h200);
    nxt(); #1;
    chk("st_hold_wdata", 64'(mem_wdata), 64'h1234);
    chk("st_hold_be", 64'(mem_be), 64'h3);
    nxt(); mem_gnt = 1'b1; #1;
    chk("st_gnt", 64'(lsu_gnt), 64'd1);
    nxt(); mem_gnt = 1'b0; lsu_req = 1'b0; #1;
    chk("st_no_early_ack", 64'(lsu_rvalid), 64'd0);
    nxt(); mem_rvalid = 1'b1; #1;
    chk("st_ack", 64'(lsu_rvalid), 64'd1);
    $display("store 0x200 acknowledged");
    nxt(); mem_rvalid = 1'b0; lsu_we = 1'b0; #1;
    chk("st_idle", 64'(mem_req), 64'd0);

    // ---------------- starvation guard ----------------
    nxt(); if_req = 1'b1; if_addr = 32'h40; lsu_req = 1'b1; lsu_addr = 32'h300; lsu_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      // REQ cycle with immediate accept
      nxt(); mem_gnt = 1'b1; #1;
      chk("arb_if_gnt", 64'(if_gnt), 64'(exp_if_order[k]));
      chk("arb_lsu_gnt", 64'(lsu_gnt), 64'(!exp_if_order[k]));
      chk("arb_streak", 64'(dut.streak), 64'(exp_streak[k]));
      if (exp_if_order[k]) begin
        chk("arb_if_addr", 64'(mem_addr), 64'h40);
        chk("arb_if_be", 64'(mem_be), 64'hF);
      end
      $display("arb txn %0d granted to %s", k, if_gnt ? "IF" : "LSU");
      // RESP cycle with immediate response
      nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(k); #1;
      chk("arb_if_rvalid", 64'(if_rvalid), 64'(exp_if_order[k]));
      chk("arb_lsu_rvalid", 64'(lsu_rvalid), 64'(!exp_if_order[k]));
      // IDLE bubble, arbitration for the next transaction
      nxt(); mem_rvalid = 1'b0;
      if (k == 9) begin
        if_req = 1'b0; lsu_req = 1'b0;
      end
      #1;
      chk("arb_bubble", 64'(mem_req), 64'd0);
    end

    // ---------------- flush during RESP ----------------
    nxt(); if_req = 1'b1; if_addr = 32'h40;
    nxt(); mem_gnt = 1'b1; #1;
    chk("fl_if_gnt", 64'(if_gnt), 64'd1);
    nxt(); mem_gnt = 1'b0; if_req = 1'b0; if_flush = 1'b1; #1;
    chk("fl_rvalid_0", 64'(if_rvalid), 64'd0);
    nxt(); if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA; #1;
    chk("fl_dropped", 64'(if_rvalid), 64'd0);
    $display("flushed fetch 0x40 response dropped");
    nxt(); mem_rvalid = 1'b0; #1;
    chk("fl_idle", 64'(mem_req), 64'd0);
    nxt(); if_req = 1'b1; if_addr = 32'h44;
    nxt(); mem_gnt = 1'b1; #1;
    chk("fl2_gnt", 64'(if_gnt), 64'd1);
    chk("fl2_addr", 64'(mem_addr), 64'h44);
    nxt(); mem_gnt = 1'b0; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555; #1;
    chk("fl2_rvalid", 64'(if_rvalid), 64'd1);
    chk("fl2_rdata", 64'(if_rdata), 64'h5555);
    $display("fetch 0x44 returned %h", if_rdata);
    nxt(); mem_rvalid = 1'b0;

    // ---------------- flush coinciding with rvalid ----------------
    nxt(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500;
    nxt(); mem_gnt = 1'b1; if_req = 1'b1; if_addr = 32'h80; #1;
    chk("co_lsu_gnt", 64'(lsu_gnt), 64'd1);
    chk("co_if_wait", 64'(if_gnt), 64'd0);
    nxt(); mem_gnt = 1'b0; lsu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; if_flush = 1'b1; #1;
    chk("co_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
    chk("co_lsu_rdata", 64'(lsu_rdata), 64'h77);
    chk("co_if_rvalid_l", 64'(if_rvalid), 64'd0);
    nxt(); mem_rvalid = 1'b0; if_flush = 1'b0;
    nxt(); mem_gnt = 1'b1; #1;
    chk("co_if_gnt", 64'(if_gnt), 64'd1);
    chk("co_if_addr", 64'(mem_addr), 64'h80);
    nxt(); mem_gnt = 1'b0; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88; if_flush = 1'b1; #1;
    chk("co_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("co_lsu_quiet", 64'(lsu_rvalid), 64'd0);
    $display("fetch 0x80 flushed on response cycle");
    nxt(); mem_rvalid = 1'b0; if_flush = 1'b0;

    // ---------------- reset during REQ ----------------
    nxt(); if_req = 1'b1; if_addr = 32'h90; lsu_req = 1'b1; lsu_addr = 32'h600;
    nxt(); #1;
    chk("rr_req", 64'(mem_req), 64'd1);
    chk("rr_streak_pre", 64'(dut.streak), 64'd1);
    rst_n = 1'b0; #1;
    chk("rr_req_async", 64'(mem_req), 64'd0);
    chk("rr_streak", 64'(dut.streak), 64'd0);
    chk("rr_state", 64'(dut.state), 64'd0);
    if_req = 1'b0; lsu_req = 1'b0;
    nxt(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99; #1;
    chk("rr_late_if", 64'(if_rvalid), 64'd0);
    chk("rr_late_lsu", 64'(lsu_rvalid), 64'd0);
    nxt(); #1;
    chk("rr_late_lsu2", 64'(lsu_rvalid), 64'd0);
    chk("rr_idle", 64'(mem_req), 64'd0);
    $display("reset during REQ aborted transaction");
    nxt(); mem_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
